// File: rtl/buffer_pixeles_escritura_pkg.sv
// Constants shared by the read-side and write-side pixel buffers between the filter and memory.
// Byte lanes in a memory word are ordered MSB-first: pixel 0 occupies bits [31:24].
package buffer_pixeles_escritura_pkg;
  localparam int PIXEL_W        = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / PIXEL_W;
  localparam bit LANE_MSB_FIRST = 1'b1;

  function automatic int lane_lsb(input int k);
    return LANE_MSB_FIRST ? WORD_W - PIXEL_W * (k + 1) : PIXEL_W * k;
  endfunction
endpackage

// File: rtl/buffer_pixeles_escritura_fifo.sv
// Word FIFO between the pixel packer and the memory-write controller; first-word fall-through.
// The head output reads zero when the FIFO is empty so that stale words never show on memory_data.
module fifo_palabras_mem #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WORD_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [WORD_W-1:0]          o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/buffer_pixeles_escritura.sv
// Packs four filtered pixels MSB-first into 32-bit words and queues them for the memory writer.
// A flush commits a partial word padded with PAD, waiting for FIFO space if necessary.
module buffer_pixeles_escritura
  import buffer_pixeles_escritura_pkg::*;
#(
  parameter int                 DEPTH = 4,
  parameter logic [PIXEL_W-1:0] PAD   = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_W-1:0]         pixel,
  input  logic                       write_pixel,
  input  logic                       flush,
  input  logic                       read_mem_data,
  output logic [WORD_W-1:0]          memory_data,
  output logic                       data_available,
  output logic                       space_available,
  output logic [$clog2(DEPTH+1)-1:0] word_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = WORD_W - PIXEL_W;

  logic [1:0]        r_idx;
  logic              r_flush_pend;
  logic [BW-1:0]     r_bytes;

  logic              w_full;
  logic              w_accept;
  logic              w_push;
  logic [WORD_W-1:0] w_push_word;
  logic [1:0]        w_idx_nxt;
  logic              w_pend_nxt;
  logic [BW-1:0]     w_bytes_nxt;

  function automatic logic [WORD_W-1:0] pad_word(input logic [BW-1:0] b, input logic [1:0] n);
    logic [WORD_W-1:0] w;
    w = {b, PAD};
    for (int k = 0; k < BYTES_PER_WORD; k++)
      if (k >= int'(n)) w[lane_lsb(k) +: PIXEL_W] = PAD;
    return w;
  endfunction

  assign w_full          = (word_count == CW'(DEPTH));
  assign space_available = ((r_idx != 2'd3) || !w_full) && !(r_flush_pend && w_full);
  assign w_accept        = write_pixel && space_available;
  assign data_available  = (word_count != '0);

  always_comb begin
    w_push      = 1'b0;
    w_push_word = {r_bytes, pixel};
    w_idx_nxt   = r_idx;
    w_pend_nxt  = r_flush_pend || flush;
    w_bytes_nxt = r_bytes;
    if (w_accept && (r_idx == 2'd3)) begin
      w_push     = 1'b1;
      w_idx_nxt  = 2'd0;
      w_pend_nxt = 1'b0;
    end else begin
      if (w_accept) w_bytes_nxt[lane_lsb(int'(r_idx)) - PIXEL_W +: PIXEL_W] = pixel;
      w_idx_nxt = r_idx + {1'b0, w_accept};
      // The pixel of this cycle is packed before a flush looks at the partial word.
      if (w_pend_nxt) begin
        if (w_idx_nxt == 2'd0) begin
          w_pend_nxt = 1'b0;
        end else if (!w_full) begin
          w_push      = 1'b1;
          w_push_word = pad_word(w_bytes_nxt, w_idx_nxt);
          w_idx_nxt   = 2'd0;
          w_pend_nxt  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx        <= 2'd0;
      r_flush_pend <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_bytes <= w_bytes_nxt;
  end

  fifo_palabras_mem #(
    .DEPTH (DEPTH),
    .WORD_W(WORD_W)
  ) u_fifo (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_push     (w_push),
    .i_push_data(w_push_word),
    .i_pop      (read_mem_data),
    .o_head     (memory_data),
    .o_count    (word_count)
  );
endmodule

// File: tb/tb_buffer_pixeles_escritura.sv
// Scenario bench for the write-side pixel buffer; expected words are queued as pixels are driven.
module tb_buffer_pixeles_escritura;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pixel;
  logic        write_pixel;
  logic        flush;
  logic        read_mem_data;
  logic [31:0] memory_data;
  logic        data_available;
  logic        space_available;
  logic [2:0]  word_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  buffer_pixeles_escritura #(.DEPTH(4), .PAD(8'h00)) dut (
    .clk(clk), .reset(reset), .pixel(pixel), .write_pixel(write_pixel), .flush(flush),
    .read_mem_data(read_mem_data), .memory_data(memory_data), .data_available(data_available),
    .space_available(space_available), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] p);
    pixel = p; write_pixel = 1'b1;
    cyc();
    write_pixel = 1'b0;
  endtask

  task automatic fill_words(input int n, input logic [7:0] base);
    for (int w = 0; w < n; w++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = base + 8'(4*w); b1 = b0 + 8'd1; b2 = b0 + 8'd2; b3 = b0 + 8'd3;
      exp_q.push_back({b0, b1, b2, b3});
      wr(b0); wr(b1); wr(b2); wr(b3);
    end
  endtask

  task automatic pop_check(input string nm);
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL %s: got %h expected <empty queue>", nm, memory_data);
    end else begin
      if (data_available !== 1'b1 || memory_data !== exp_q[0]) begin
        bad++; $display("FAIL %s: got da=%b data=%h expected da=1 data=%h", nm, data_available, memory_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    read_mem_data = 1'b1;
    cyc();
    read_mem_data = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; pixel = 8'h00; write_pixel = 1'b0; flush = 1'b0; read_mem_data = 1'b0;
    cyc(); cyc();
    total++; if (data_available !== 1'b0) begin bad++; $display("FAIL rst_da: got %b expected 0", data_available); end
    total++; if (memory_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h expected 00000000", memory_data); end
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL rst_cnt: got %0d expected 0", word_count); end
    total++; if (space_available !== 1'b1) begin bad++; $display("FAIL rst_space: got %b expected 1", space_available); end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_pack();
    exp_q.push_back(32'haabbccdd);
    wr(8'haa); wr(8'hbb); wr(8'hcc); wr(8'hdd);
    total++; if (data_available !== 1'b1) begin bad++; $display("FAIL pack_da: got %b expected 1", data_available); end
    total++; if (word_count !== 3'd1) begin bad++; $display("FAIL pack_cnt: got %0d expected 1", word_count); end
    pop_check("pack_word");
    total++; if (data_available !== 1'b0) begin bad++; $display("FAIL pack_pop_da: got %b expected 0", data_available); end
  endtask

  task automatic test_flush();
    exp_q.push_back(32'h12340000);
    wr(8'h12); wr(8'h34);
    flush = 1'b1; cyc(); flush = 1'b0;
    total++; if (word_count !== 3'd1) begin bad++; $display("FAIL flush_cnt: got %0d expected 1", word_count); end
    pop_check("flush_word");
    flush = 1'b1; cyc(); flush = 1'b0; cyc();
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL flush_idle_cnt: got %0d expected 0", word_count); end
    exp_q.push_back(32'h01020304);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    pop_check("after_flush_word");
  endtask

  task automatic test_full();
    fill_words(4, 8'h10);
    total++; if (word_count !== 3'd4) begin bad++; $display("FAIL full_cnt: got %0d expected 4", word_count); end
    wr(8'ha0); wr(8'ha1); wr(8'ha2);
    total++; if (space_available !== 1'b0) begin bad++; $display("FAIL full_space: got %b expected 0", space_available); end
    wr(8'hee);
    total++; if (word_count !== 3'd4) begin bad++; $display("FAIL full_drop_cnt: got %0d expected 4", word_count); end
    pop_check("full_pop0");
    total++; if (space_available !== 1'b1) begin bad++; $display("FAIL full_space_free: got %b expected 1", space_available); end
    exp_q.push_back(32'ha0a1a2a3);
    wr(8'ha3);
    total++; if (word_count !== 3'd4) begin bad++; $display("FAIL full_refill_cnt: got %0d expected 4", word_count); end
    for (int i = 0; i < 4; i++) pop_check("full_drain");
    total++; if (data_available !== 1'b0) begin bad++; $display("FAIL full_empty_da: got %b expected 0", data_available); end
  endtask

  task automatic test_back_to_back();
    fill_words(2, 8'hb0);
    wr(8'hd0); wr(8'hd1); wr(8'hd2);
    total++;
    if (memory_data !== exp_q[0]) begin bad++; $display("FAIL b2b_head: got %h expected %h", memory_data, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(32'hd0d1d2d3);
    pixel = 8'hd3; write_pixel = 1'b1; read_mem_data = 1'b1;
    cyc();
    write_pixel = 1'b0; read_mem_data = 1'b0;
    total++; if (word_count !== 3'd2) begin bad++; $display("FAIL b2b_cnt: got %0d expected 2", word_count); end
    pop_check("b2b_pop1");
    pop_check("b2b_pop2");
  endtask

  task automatic test_flush_with_pixel();
    exp_q.push_back(32'habcdef77);
    wr(8'hab); wr(8'hcd); wr(8'hef);
    pixel = 8'h77; write_pixel = 1'b1; flush = 1'b1;
    cyc();
    write_pixel = 1'b0; flush = 1'b0;
    cyc();
    total++; if (word_count !== 3'd1) begin bad++; $display("FAIL fwp_cnt: got %0d expected 1", word_count); end
    pop_check("fwp_word");
    cyc();
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL fwp_extra: got %0d expected 0", word_count); end
  endtask

  task automatic test_flush_pending();
    fill_words(4, 8'h40);
    wr(8'h5a); wr(8'h5b);
    flush = 1'b1; cyc(); flush = 1'b0;
    total++; if (word_count !== 3'd4) begin bad++; $display("FAIL fpend_cnt: got %0d expected 4", word_count); end
    total++; if (space_available !== 1'b0) begin bad++; $display("FAIL fpend_space: got %b expected 0", space_available); end
    pop_check("fpend_pop0");
    exp_q.push_back(32'h5a5b0000);
    cyc();
    total++; if (word_count !== 3'd4) begin bad++; $display("FAIL fpend_commit_cnt: got %0d expected 4", word_count); end
    for (int i = 0; i < 4; i++) pop_check("fpend_drain");
  endtask

  task automatic test_reset_mid();
    fill_words(3, 8'h80);
    wr(8'hc0); wr(8'hc1);
    reset = 1'b0; cyc(); reset = 1'b1;
    exp_q.delete();
    total++; if (word_count !== 3'd0) begin bad++; $display("FAIL rmid_cnt: got %0d expected 0", word_count); end
    total++; if (data_available !== 1'b0) begin bad++; $display("FAIL rmid_da: got %b expected 0", data_available); end
    total++; if (memory_data !== 32'h0) begin bad++; $display("FAIL rmid_data: got %h expected 00000000", memory_data); end
    exp_q.push_back(32'he1e2e3e4);
    wr(8'he1); wr(8'he2); wr(8'he3); wr(8'he4);
    total++; if (word_count !== 3'd1) begin bad++; $display("FAIL rmid_fresh_cnt: got %0d expected 1", word_count); end
    pop_check("rmid_fresh_word");
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush();
    test_full();
    test_back_to_back();
    test_flush_with_pixel();
    test_flush_pending();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/buffer_pixeles_escritura.md
# buffer_pixeles_escritura

Write-side counterpart of the pixel buffer on the memory read path. Accepts one 8-bit processed pixel at a time from the filter datapath and packs four consecutive pixels into a 32-bit memory word, MSB-first. Completed words go into a small word FIFO that the memory-write controller drains with a strobe. Sits between the filter output stage and the memory-write interface.

## Interface
- DEPTH, 4, number of 32-bit words in the word FIFO; power of two, ≥2.
- PAD, 8'h00, byte value used to fill unused byte lanes on a flush.

- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- pixel  input  8  pixel from the filter datapath.
- write_pixel  input  1  push strobe; one pixel is accepted per cycle when asserted and space_available=1.
- flush  input  1  single-cycle request to commit a partially packed word, padded with PAD.
- read_mem_data  input  1  pop strobe from the memory-write controller; honoured only when data_available=1.
- memory_data  output  32  head word of the FIFO; first-word fall-through; valid while data_available=1.
- data_available  output  1  FIFO holds ≥1 word.
- space_available  output  1  a pixel written this cycle is accepted.
- word_count  output  clog2(DEPTH+1)  words currently in the FIFO.

## Operation
- Packer: 2-bit byte index `idx` plus a 24-bit shift register for bytes 0..2. Pixel k of a word lands in memory_data[31-8k -: 8]. Example: aa, bb, cc, dd gives 32'haabbccdd.
- Accept rule: space_available = (idx < 3) OR (word_count < DEPTH). It is computed from registered state only. A same-cycle read_mem_data does not free space for that cycle's write (no bypass).
- Accepted pixel with idx < 3: the byte is stored and idx is incremented.
- Accepted pixel with idx = 3: the full word is pushed into the FIFO on that edge and idx returns to 0.
- Writes with space_available = 0 are dropped silently, with no state change.
- Flush: sets a sticky flush_pend flag. When flush_pend = 1 and idx > 0 and word_count < DEPTH, the partial word is pushed with lanes idx..3 set to PAD, idx goes to 0 and flush_pend clears. If idx = 0, flush_pend clears without pushing a word.
- flush and write_pixel in the same cycle: the pixel is packed first, then the flush applies. A pixel that completes the word performs the normal commit and clears flush_pend; no extra word is emitted.
- While flush_pend = 1 and the FIFO is full, space_available is forced to 0 so that packing cannot run ahead of the pending padded commit.
- FIFO: circular buffer with wr_ptr and rd_ptr of width clog2(DEPTH), wrapping modulo DEPTH, plus word_count.
  - Push and pop in the same cycle leave word_count unchanged.
  - Pop while empty is ignored.
  - Push while full cannot occur because of the accept rule.

## Timing
- Reset values: memory_data = 32'h0 (no stored data), data_available = 0, space_available = 1, word_count = 0. idx, flush_pend and both pointers are 0; FIFO contents are cleared.
- Reset has priority over all inputs. Asserting it mid-word discards the partial bytes and all FIFO words; there is no flush on reset.
- Latency from the 4th pixel strobe (edge N) to data_available = 1 and memory_data valid is 1 cycle: both are visible after edge N.
- Flush commit happens on the edge where flush is sampled if the FIFO has space; otherwise on the first edge after a pop frees a slot.
- Pop: memory_data advances to the next word, and data_available/word_count update, after the edge where read_mem_data = 1.
- Sustained throughput: 1 pixel/cycle in, with 1 word every 4 cycles available for output.

## Structure
- Shared package (filter/memory common): PIXEL_W = 8, WORD_W = 32, BYTES_PER_WORD = 4, and the byte-lane ordering constant (MSB-first). The read-side buffer uses the same constants.
- One sub-module: fifo_palabras_mem (DEPTH × 32 FIFO with push/pop/count, first-word fall-through). The packer and flush logic stay in the top level.

## Test plan
- Reset then push aa, bb, cc, dd on consecutive cycles → next cycle data_available = 1, memory_data = 32'haabbccdd, word_count = 1. Pop → data_available = 0.
- Push 12, 34, then flush → memory_data = 32'h12340000, idx = 0. Flush with idx = 0 → no word emitted.
- Fill 4 words (DEPTH = 4), then push 3 more bytes → space_available drops to 0 before the 4th byte. A write then is dropped. One pop → space_available = 1, and the 4th byte commits the 5th word in order.
- Simultaneous push-completing write and pop with word_count = 2 → word_count stays 2, and the pop order matches the push order across the pointer wrap.
- flush asserted together with the 4th pixel 77 after ab, cd, ef → exactly one word 32'habcdef77, with no padded extra word.
- Reset asserted with 2 bytes packed and 3 words stored → after the edge word_count = 0, data_available = 0, and the next 4 pixels form a fresh word.
